// File: rtl/jtpang_obj_draw_if.sv
// Signal bundle between the object scanner, the object ROM slot and the line buffer.
// The renderer uses the master modport; the surrounding logic or bench uses slave.
interface jtpang_obj_draw_if;
    logic        draw;
    logic        busy;
    logic [11:0] code;
    logic [3:0]  row;
    logic        hflip;
    logic [8:0]  xpos;
    logic [3:0]  pal;
    logic        rom_cs;
    logic [16:0] rom_addr;
    logic [31:0] rom_data;
    logic        rom_ok;
    logic        buf_we;
    logic [8:0]  buf_addr;
    logic [7:0]  buf_din;

    modport master (
        input  draw, code, row, hflip, xpos, pal, rom_data, rom_ok,
        output busy, rom_cs, rom_addr, buf_we, buf_addr, buf_din
    );

    modport slave (
        output draw, code, row, hflip, xpos, pal, rom_data, rom_ok,
        input  busy, rom_cs, rom_addr, buf_we, buf_addr, buf_din
    );
endinterface

// File: rtl/jtpang_obj_draw.sv
// Per-sprite line renderer: fetches two 32-bit planar words for one 16-pixel row
// and writes the opaque 4bpp pixels to the object line buffer.
module jtpang_obj_draw #(
    parameter logic [3:0] TRANSP  = 4'hf,
    parameter logic [8:0] HOFFSET = 9'd0
) (
    input logic              rst,
    input logic              clk,
    jtpang_obj_draw_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_WAIT = 2'd2,
        ST_DRAW = 2'd3
    } state_t;

    state_t      state_q, state_d;

    logic [11:0] code_q,     code_d;
    logic [3:0]  row_q,      row_d;
    logic        hflip_q,    hflip_d;
    logic [3:0]  pal_q,      pal_d;
    logic [8:0]  x_q,        x_d;
    logic        half_q,     half_d;
    logic        first_q,    first_d;
    logic [31:0] sr_q,       sr_d;
    logic [2:0]  cnt_q,      cnt_d;
    logic        busy_q,     busy_d;
    logic        rom_cs_q,   rom_cs_d;
    logic [16:0] rom_addr_q, rom_addr_d;
    logic        buf_we_q,   buf_we_d;
    logic [8:0]  buf_addr_q, buf_addr_d;
    logic [7:0]  buf_din_q,  buf_din_d;

    logic        accept;
    logic        last_pix;
    logic [3:0]  pix;
    logic [31:0] sr_shift;

    // busy_q stays high for the cycle of the final write slot, so gating on it
    // keeps a draw from being taken until the scanner has seen busy=0.
    assign accept   = (state_q == ST_IDLE) && !busy_q && bus.draw;
    assign last_pix = (cnt_q == 3'd7);

    // Each byte is one bit plane; pixel bit gi comes from byte gi.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_plane
            assign pix[gi] = hflip_q ? sr_q[8*gi] : sr_q[8*gi+7];
            assign sr_shift[8*gi +: 8] = hflip_q ? {1'b0, sr_q[8*gi+1 +: 7]}
                                                 : {sr_q[8*gi +: 7], 1'b0};
        end
    endgenerate

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)     state_d = ST_ADDR;
            ST_ADDR:                 state_d = ST_WAIT;
            ST_WAIT: if (bus.rom_ok) state_d = ST_DRAW;
            ST_DRAW: if (last_pix)   state_d = first_q ? ST_ADDR : ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    // Output and datapath logic
    always_comb begin
        code_d     = code_q;
        row_d      = row_q;
        hflip_d    = hflip_q;
        pal_d      = pal_q;
        x_d        = x_q;
        half_d     = half_q;
        first_d    = first_q;
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        rom_addr_d = rom_addr_q;
        buf_we_d   = 1'b0;
        buf_addr_d = buf_addr_q;
        buf_din_d  = buf_din_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    code_d     = bus.code;
                    row_d      = bus.row;
                    hflip_d    = bus.hflip;
                    pal_d      = bus.pal;
                    x_d        = bus.xpos + HOFFSET;
                    half_d     = bus.hflip;
                    first_d    = 1'b1;
                    rom_addr_d = {bus.code, bus.row, bus.hflip};
                end
            end
            ST_WAIT: begin
                if (bus.rom_ok) begin
                    sr_d  = bus.rom_data;
                    cnt_d = 3'd0;
                end
            end
            ST_DRAW: begin
                buf_we_d   = (pix != TRANSP);
                buf_addr_d = x_q;
                buf_din_d  = {pal_q, pix};
                x_d        = x_q + 9'd1;
                sr_d       = sr_shift;
                cnt_d      = cnt_q + 3'd1;
                if (last_pix && first_q) begin
                    half_d     = ~half_q;
                    first_d    = 1'b0;
                    rom_addr_d = {code_q, row_q, ~half_q};
                end
            end
            default: ;
        endcase

        rom_cs_d = (state_d == ST_ADDR) || (state_d == ST_WAIT);
        busy_d   = (state_d != ST_IDLE) || (state_q == ST_DRAW);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_q     <= '0;
            row_q      <= '0;
            hflip_q    <= 1'b0;
            pal_q      <= '0;
            x_q        <= '0;
            half_q     <= 1'b0;
            first_q    <= 1'b0;
            sr_q       <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            rom_cs_q   <= 1'b0;
            rom_addr_q <= '0;
            buf_we_q   <= 1'b0;
            buf_addr_q <= '0;
            buf_din_q  <= '0;
        end else begin
            code_q     <= code_d;
            row_q      <= row_d;
            hflip_q    <= hflip_d;
            pal_q      <= pal_d;
            x_q        <= x_d;
            half_q     <= half_d;
            first_q    <= first_d;
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            rom_cs_q   <= rom_cs_d;
            rom_addr_q <= rom_addr_d;
            buf_we_q   <= buf_we_d;
            buf_addr_q <= buf_addr_d;
            buf_din_q  <= buf_din_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.rom_cs   = rom_cs_q;
    assign bus.rom_addr = rom_addr_q;
    assign bus.buf_we   = buf_we_q;
    assign bus.buf_addr = buf_addr_q;
    assign bus.buf_din  = buf_din_q;

endmodule

// File: tb/tb_jtpang_obj_draw.sv
// Scoreboard bench for jtpang_obj_draw: stimulus pushes hand-computed ROM addresses,
// line-buffer writes and busy lengths; independent monitors pop and compare.
module tb_jtpang_obj_draw;

    logic clk = 1'b0;
    logic rst = 1'b1;

    jtpang_obj_draw_if bus();

    jtpang_obj_draw #(.TRANSP(4'hf), .HOFFSET(9'd0)) dut (
        .rst (rst),
        .clk (clk),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [16:0] exp_addr_q[$];
    logic [16:0] exp_wr_q[$];
    int          exp_busy_q[$];

    logic [31:0] rom_w0 = 32'h0;
    logic [31:0] rom_w1 = 32'h0;
    int          ok_delay  = 2;
    bit          ok_always = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endfunction

    function automatic void fail_now(input string name, input string what);
        n_cmp++;
        n_err++;
        $display("FAIL %s: %s", name, what);
    endfunction

    // ROM slot model: ok arrives ok_delay cycles after cs rises; the ADDR-cycle word is garbage
    initial begin : rom_model
        int          cs_cnt;
        logic [16:0] cs_addr;
        cs_cnt  = 0;
        cs_addr = '0;
        bus.rom_ok   = 1'b0;
        bus.rom_data = 32'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                cs_cnt     = 0;
                bus.rom_ok = 1'b0;
            end else if (bus.rom_cs) begin
                cs_cnt++;
                if (cs_cnt == 1) begin
                    cs_addr = bus.rom_addr;
                    if (exp_addr_q.size() == 0)
                        fail_now("rom_addr", $sformatf("unexpected fetch %h, required none", bus.rom_addr));
                    else
                        check("rom_addr", {15'b0, bus.rom_addr}, {15'b0, exp_addr_q.pop_front()});
                end else begin
                    check("rom_addr_stable", {15'b0, bus.rom_addr}, {15'b0, cs_addr});
                end
                bus.rom_ok   = ok_always || (cs_cnt >= ok_delay);
                bus.rom_data = (cs_cnt >= 2) ? (bus.rom_addr[0] ? rom_w1 : rom_w0) : 32'h5A5A_A5A5;
            end else begin
                cs_cnt       = 0;
                bus.rom_ok   = ok_always;
                bus.rom_data = 32'h5A5A_A5A5;
            end
        end
    end

    // Line-buffer write monitor
    initial begin : wr_monitor
        forever begin
            @(negedge clk);
            if (!rst && bus.buf_we) begin
                if (exp_wr_q.size() == 0)
                    fail_now("buf_write", $sformatf("unexpected write x=%0d din=%h, required none",
                                                    bus.buf_addr, bus.buf_din));
                else
                    check("buf_write", {15'b0, bus.buf_addr, bus.buf_din}, {15'b0, exp_wr_q.pop_front()});
            end
        end
    end

    // busy length monitor; a reset abort discards the measurement
    initial begin : busy_monitor
        bit act;
        int len;
        act = 1'b0;
        len = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                act = 1'b0;
                len = 0;
            end else if (bus.busy) begin
                act = 1'b1;
                len++;
            end else if (act) begin
                act = 1'b0;
                if (exp_busy_q.size() == 0)
                    fail_now("busy_len", $sformatf("unexpected busy run of %0d, required none", len));
                else
                    check("busy_len", len, exp_busy_q.pop_front());
                len = 0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic exp_write(input logic [8:0] x, input logic [7:0] d);
        exp_wr_q.push_back({x, d});
    endtask

    task automatic exp_run(input logic [8:0] x0, input int n, input logic [7:0] d);
        for (int i = 0; i < n; i++) begin
            logic [8:0] a;
            a = x0 + i[8:0];
            exp_wr_q.push_back({a, d});
        end
    endtask

    // Waits for busy=0 (bounded), then issues a one-cycle draw
    task automatic draw_sprite(input logic [11:0] c, input logic [3:0] r, input logic h,
                               input logic [8:0] x, input logic [3:0] p,
                               input logic [31:0] w0, input logic [31:0] w1,
                               input int dly, input bit always_ok, input int busy_len);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (bus.busy && t < 2000);
        if (bus.busy) begin
            fail_now("draw_wait", "busy never dropped within 2000 cycles");
            return;
        end
        rom_w0    = w0;
        rom_w1    = w1;
        ok_delay  = dly;
        ok_always = always_ok;
        bus.code  = c;
        bus.row   = r;
        bus.hflip = h;
        bus.xpos  = x;
        bus.pal   = p;
        bus.draw  = 1'b1;
        exp_addr_q.push_back({c, r, h});
        exp_addr_q.push_back({c, r, ~h});
        exp_busy_q.push_back(busy_len);
        $display("draw code=%h row=%h hflip=%0d x=%0d pal=%h w0=%h w1=%h ok_delay=%0d ok_always=%0d",
                 c, r, h, x, p, w0, w1, dly, always_ok);
        @(negedge clk);
        bus.draw = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (bus.busy && t < 2000);
        if (bus.busy) fail_now("idle_wait", "busy never dropped within 2000 cycles");
        repeat (2) @(negedge clk);
    endtask

    initial begin : stim
        bus.draw  = 1'b0;
        bus.code  = '0;
        bus.row   = '0;
        bus.hflip = 1'b0;
        bus.xpos  = '0;
        bus.pal   = '0;
        rst       = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_busy",     {31'b0, bus.busy},     32'h0);
        check("rst_rom_cs",   {31'b0, bus.rom_cs},   32'h0);
        check("rst_rom_addr", {15'b0, bus.rom_addr}, 32'h0);
        check("rst_buf_we",   {31'b0, bus.buf_we},   32'h0);
        check("rst_buf_addr", {23'b0, bus.buf_addr}, 32'h0);
        check("rst_buf_din",  {24'b0, bus.buf_din},  32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic sprite: fetches 0246A then 0246B
        exp_run(9'd100, 8, 8'h35);
        exp_run(9'd108, 8, 8'h30);
        draw_sprite(12'h123, 4'h5, 1'b0, 9'd100, 4'h3, 32'h00FF00FF, 32'h0, 2, 1'b0, 21);
        wait_idle();

        // Flip: screen-left half is word 1
        exp_run(9'd100, 8, 8'h30);
        exp_run(9'd108, 8, 8'h35);
        draw_sprite(12'h123, 4'h5, 1'b1, 9'd100, 4'h3, 32'h00FF00FF, 32'h0, 2, 1'b0, 21);
        wait_idle();

        // Pixel order within bytes, flipped
        exp_write(9'd200, 8'hA8);
        exp_write(9'd201, 8'hA4);
        exp_write(9'd202, 8'hA2);
        exp_write(9'd203, 8'hA1);
        exp_run(9'd204, 12, 8'hA0);
        draw_sprite(12'h0AB, 4'hC, 1'b1, 9'd200, 4'hA, 32'h0, 32'h01020408, 2, 1'b0, 21);
        wait_idle();

        // Same word, not flipped
        exp_run(9'd200, 4, 8'hA0);
        exp_write(9'd204, 8'hA1);
        exp_write(9'd205, 8'hA2);
        exp_write(9'd206, 8'hA4);
        exp_write(9'd207, 8'hA8);
        exp_run(9'd208, 8, 8'hA0);
        draw_sprite(12'h0AB, 4'hC, 1'b0, 9'd200, 4'hA, 32'h01020408, 32'h0, 2, 1'b0, 21);
        wait_idle();

        // Transparency + wrap: only the last pixel is opaque, at (508+15) mod 512 = 11
        exp_write(9'd11, 8'h70);
        draw_sprite(12'h7FF, 4'hF, 1'b0, 9'd508, 4'h7, 32'hFFFFFFFF, 32'hFEFEFEFE, 2, 1'b0, 21);
        wait_idle();

        // Opaque wrap: 505..511 then 0..8
        exp_run(9'd505, 16, 8'h10);
        draw_sprite(12'h055, 4'h3, 1'b0, 9'd505, 4'h1, 32'h0, 32'h0, 2, 1'b0, 21);
        wait_idle();

        // Stale ok: rom_ok held high, ADDR-cycle data is garbage
        exp_write(9'd0, 8'h28);
        exp_run(9'd1, 14, 8'h20);
        exp_write(9'd15, 8'h21);
        draw_sprite(12'h001, 4'h1, 1'b0, 9'd0, 4'h2, 32'h80000000, 32'h00000001, 2, 1'b1, 21);
        wait_idle();

        // Long WAIT (ok 40 cycles after cs), with an ignored draw while busy
        exp_run(9'd300, 8, 8'hF4);
        exp_run(9'd308, 8, 8'hFC);
        draw_sprite(12'h3C0, 4'h0, 1'b0, 9'd300, 4'hF, 32'h00FF0000, 32'hFFFF0000, 40, 1'b0, 97);
        repeat (10) @(negedge clk);
        bus.code = 12'hFFF;
        bus.xpos = 9'd50;
        bus.draw = 1'b1;
        @(negedge clk);
        bus.draw = 1'b0;

        // Back-to-back: issued in the cycle busy falls
        exp_run(9'd400, 8, 8'h35);
        exp_run(9'd408, 8, 8'h30);
        draw_sprite(12'h123, 4'h5, 1'b0, 9'd400, 4'h3, 32'h00FF00FF, 32'h0, 2, 1'b0, 21);
        wait_idle();

        // Reset during pixel 3 of the first word: only pixels 0 and 1 are seen
        ok_delay  = 2;
        ok_always = 1'b0;
        rom_w0    = 32'h0;
        rom_w1    = 32'h0;
        exp_run(9'd20, 2, 8'h50);
        exp_addr_q.push_back({12'h010, 4'h2, 1'b0});
        bus.code  = 12'h010;
        bus.row   = 4'h2;
        bus.hflip = 1'b0;
        bus.xpos  = 9'd20;
        bus.pal   = 4'h5;
        bus.draw  = 1'b1;
        $display("draw code=010 row=2 hflip=0 x=20 pal=5, reset at pixel 3");
        @(negedge clk);
        bus.draw = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rstmid_buf_we", {31'b0, bus.buf_we}, 32'h0);
        check("rstmid_rom_cs", {31'b0, bus.rom_cs}, 32'h0);
        check("rstmid_busy",   {31'b0, bus.busy},   32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("post_rst_busy",   {31'b0, bus.busy},   32'h0);
        check("post_rst_rom_cs", {31'b0, bus.rom_cs}, 32'h0);

        // Clean restart after reset
        exp_run(9'd0, 8, 8'h35);
        exp_run(9'd8, 8, 8'h30);
        draw_sprite(12'h123, 4'h5, 1'b0, 9'd0, 4'h3, 32'h00FF00FF, 32'h0, 2, 1'b0, 21);
        wait_idle();
        repeat (5) @(negedge clk);

        check("writes_left",  exp_wr_q.size(),   32'h0);
        check("fetches_left", exp_addr_q.size(), 32'h0);
        check("busy_left",    exp_busy_q.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
